des_key_sched_seq: RTL and testbench
====================================

Name: des_key_sched_seq

Overview:
Sequential DES/3DES key-schedule engine. Selects one of NUM_KEYS 64-bit keys, applies PC-1, then performs the per-round C/D rotations and PC-2 compression, one round per handshake. Emits the 16 48-bit round subkeys in encrypt order (K1..K16) or decrypt order (K16..K1) over a valid/ready stream. Feeds the round datapath of the 3DES core; each stage of EDE/DED re-runs the engine with its own key slot and direction.

Parameters:
NUM_KEYS, 3, number of 64-bit key slots on key_in (1 = single DES, 3 = 3DES keying option 1)
KSEL_W, 2, width of key_sel; must satisfy 2**KSEL_W >= NUM_KEYS

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
key_in  in  64*NUM_KEYS  key slots; slot i at [64*i+63 : 64*i]; bit 64*i+63 = DES key bit 1
key_sel  in  KSEL_W  slot index, sampled with start
decrypt  in  1  0 = K1..K16, 1 = K16..K1; sampled with start
start  in  1  request a schedule; accepted only when busy=0
abort  in  1  synchronous cancel of a running schedule
busy  out  1  high from accepted start until done or abort
subkey_valid  out  1  subkey/round_idx valid
subkey_ready  in  1  consumer accepts the subkey
subkey  out  48  round subkey; bit 47 = PC-2 output bit 1
round_idx  out  4  DES round number of the presented subkey (1..16 encoded 0..15)
done  out  1  one-cycle pulse after the 16th subkey handshake
err  out  1  one-cycle pulse: start rejected (bad key_sel, or parity if enabled)

Behaviour:
- Reset: busy=0, subkey_valid=0, subkey=0, round_idx=0, done=0, err=0, state IDLE, C/D=0. Asynchronous assertion, synchronous release. Reset mid-run drops everything; no done.
- States: IDLE, RUN, FIN.
- IDLE: start=1 with key_sel<NUM_KEYS: load C/D = PC-1 of the selected key (C = bits 1..28, D = 29..56), then go to RUN, busy=1.
  - Encrypt: C/D rotated left by SHIFT[1] before the first PC-2.
  - Decrypt: C/D used unrotated; rotation after 28 total shifts equals C0/D0, which is K16.
  - start with key_sel>=NUM_KEYS: err=1 for one cycle, stay IDLE.
- Latency: start accepted at edge N; subkey_valid=1 with the first subkey after edge N+1.
- RUN: subkey and round_idx are registered and held stable while valid=1 and ready=0.
  - On valid&ready, the next subkey appears on the following cycle with no bubble.
  - Encrypt advance: rotate left by SHIFT[r+1].
  - Decrypt advance: rotate right by SHIFT[r], where r is the round just emitted.
  - SHIFT = 1 for rounds 1, 2, 9, 16; 2 otherwise.
- Last handshake (round 16 in encrypt, round 1 in decrypt): go to FIN, valid=0. FIN then pulses done=1, busy=0, and returns to IDLE. A start in the same cycle as done is ignored; start is accepted from the next cycle.
- start while busy=1: ignored, no err.
- abort=1 in RUN or FIN: next cycle valid=0, busy=0, state IDLE, no done. abort wins over a simultaneous handshake. abort in IDLE has no effect.
- key_in, key_sel and decrypt are don't-care after start is accepted; the key is held internally in C/D only.
- Rotations are within 28 bits, independently on C and D.

Optional Feature:
PARITY_CHECK_EN
- Defined: on start, check each of the 8 key bytes of the selected slot for odd parity. Any failing byte rejects the start: err=1 for one cycle, stay IDLE.
- Undefined: parity bits (8, 16, ..., 64) are ignored, and err pulses only for a bad key_sel.

Decomposition:
- Package des_pkg:
  - PC1_TABLE[56] and PC2_TABLE[48] index constants
  - SHIFT_TABLE[16]
  - state enum {IDLE, RUN, FIN}
  - constants ROUNDS=16, HALF_W=28, SUBKEY_W=48
- Sub-module des_pc1: combinational 64→56 permutation, instantiated once.
- PC-2 is implemented inline from PC2_TABLE.

Test Plan:
- NUM_KEYS=3. Slot1 = 0x133457799BBCDFF1, key_sel=1, decrypt=0, ready held 1 → first subkey 0x1B02EFFC7072 with round_idx=0 one cycle after start. 16th subkey 0xCB3D8B0E17F5 with round_idx=15. done pulses once. busy is high for 18 cycles.
- Same key, decrypt=1 → first subkey 0xCB3D8B0E17F5 with round_idx=15; last subkey 0x1B02EFFC7072 with round_idx=0. The sequence is the exact reverse of the encrypt capture.
- Random ready (about 40% duty) → subkey and round_idx stable whenever valid=1 and ready=0. Exactly 16 handshakes, then done. No valid after done.
- key_sel=3 with NUM_KEYS=3 → err=1 for one cycle, busy stays 0, no valid. A second start during RUN → ignored, err=0.
- abort after the 5th handshake → valid=0 and busy=0 next cycle, no done. An immediate restart produces K1 again.
- rst_n low for 1 cycle mid-RUN → all outputs 0 asynchronously. With PARITY_CHECK_EN, key 0x133457799BBCDFF0 → err=1 and no run.

Source files
------------

// File: rtl/des_pkg.sv
// rtl/des_pkg.sv - DES key-schedule tables, state encoding, widths and half-key rotate helper
package des_pkg;
    localparam int ROUNDS   = 16;
    localparam int HALF_W   = 28;
    localparam int SUBKEY_W = 48;

    localparam int PC1_TABLE [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };

    localparam int PC2_TABLE [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    localparam int SHIFT_TABLE [ROUNDS] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    // Rotate a 28-bit half by 1 or 2 places; a doubled copy makes both directions plain slices.
    function automatic logic [HALF_W-1:0] rot_half(input logic [HALF_W-1:0] x, input int amt,
                                                   input logic right);
        logic [2*HALF_W-1:0] dbl;
        logic [HALF_W-1:0]   res;
        dbl = {x, x};
        if (right)
            res = (amt == 1) ? dbl[HALF_W:1] : dbl[HALF_W+1:2];
        else
            res = (amt == 1) ? dbl[2*HALF_W-2:HALF_W-1] : dbl[2*HALF_W-3:HALF_W-2];
        return res;
    endfunction
endpackage

// File: rtl/des_pc1.sv
// rtl/des_pc1.sv - DES PC-1 permutation, 64-bit key to 56-bit C||D (parity bits dropped)
module des_pc1
    import des_pkg::*;
(
    input  logic [63:0]         key,
    output logic [2*HALF_W-1:0] cd
);
    genvar i;
    generate
        for (i = 0; i < 2*HALF_W; i++) begin : g_pc1
            assign cd[2*HALF_W-1-i] = key[64-PC1_TABLE[i]];
        end
    endgenerate

    logic unused_parity;
    assign unused_parity = ^{key[56], key[48], key[40], key[32], key[24], key[16], key[8], key[0]};
endmodule

// File: rtl/des_key_sched_seq.sv
// rtl/des_key_sched_seq.sv - sequential DES/3DES round-subkey generator, encrypt or decrypt order
// Optional odd-parity key check on start: PARITY_CHECK_EN
module des_key_sched_seq
    import des_pkg::*;
#(
    parameter int NUM_KEYS = 3,
    parameter int KSEL_W   = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [64*NUM_KEYS-1:0] key_in,
    input  logic [KSEL_W-1:0]      key_sel,
    input  logic                   decrypt,
    input  logic                   start,
    input  logic                   abort,
    output logic                   busy,
    output logic                   subkey_valid,
    input  logic                   subkey_ready,
    output logic [SUBKEY_W-1:0]    subkey,
    output logic [3:0]             round_idx,
    output logic                   done,
    output logic                   err
);
    state_t                state_q, state_d;
    logic [HALF_W-1:0]     c_q, c_d, d_q, d_d, c_adv, d_adv;
    logic [3:0]            round_q, round_d, round_adv;
    logic                  dec_q, dec_d, valid_q, valid_d, err_q, err_d;
    logic [SUBKEY_W-1:0]   subkey_q, subkey_d;
    logic [63:0]           sel_key;
    logic                  sel_hit, key_ok, last_round;
    logic [2*HALF_W-1:0]   pc1_cd;

    function automatic logic [SUBKEY_W-1:0] pc2(input logic [2*HALF_W-1:0] cd);
        logic [SUBKEY_W-1:0] res;
        for (int i = 0; i < SUBKEY_W; i++) res[SUBKEY_W-1-i] = cd[2*HALF_W-PC2_TABLE[i]];
        return res;
    endfunction

    always_comb begin
        sel_key = '0;
        sel_hit = 1'b0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (key_sel == KSEL_W'(i)) begin
                sel_key = key_in[64*i +: 64];
                sel_hit = 1'b1;
            end
        end
    end

`ifdef PARITY_CHECK_EN
    always_comb begin
        key_ok = sel_hit;
        for (int b = 0; b < 8; b++) if (!(^sel_key[8*b +: 8])) key_ok = 1'b0;
    end
`else
    assign key_ok = sel_hit;
`endif

    des_pc1 u_pc1 (.key(sel_key), .cd(pc1_cd));

    // Decrypt walks the rotations back: undo the shift of the round just emitted.
    always_comb begin
        if (dec_q) begin
            round_adv  = round_q - 4'd1;
            c_adv      = rot_half(c_q, SHIFT_TABLE[round_q], 1'b1);
            d_adv      = rot_half(d_q, SHIFT_TABLE[round_q], 1'b1);
            last_round = (round_q == 4'd0);
        end else begin
            round_adv  = round_q + 4'd1;
            c_adv      = rot_half(c_q, SHIFT_TABLE[round_adv], 1'b0);
            d_adv      = rot_half(d_q, SHIFT_TABLE[round_adv], 1'b0);
            last_round = (round_q == 4'(ROUNDS-1));
        end
    end

    always_comb begin
        state_d  = state_q;
        c_d      = c_q;
        d_d      = d_q;
        round_d  = round_q;
        dec_d    = dec_q;
        subkey_d = subkey_q;
        valid_d  = valid_q;
        err_d    = 1'b0;
        case (state_q)
            IDLE: begin
                valid_d = 1'b0;
                if (start) begin
                    if (key_ok) begin
                        c_d     = decrypt ? pc1_cd[2*HALF_W-1:HALF_W]
                                          : rot_half(pc1_cd[2*HALF_W-1:HALF_W], SHIFT_TABLE[0], 1'b0);
                        d_d     = decrypt ? pc1_cd[HALF_W-1:0]
                                          : rot_half(pc1_cd[HALF_W-1:0], SHIFT_TABLE[0], 1'b0);
                        round_d = decrypt ? 4'(ROUNDS-1) : 4'd0;
                        dec_d   = decrypt;
                        state_d = RUN;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                end else if (!valid_q) begin
                    subkey_d = pc2({c_q, d_q});
                    valid_d  = 1'b1;
                end else if (subkey_ready) begin
                    if (last_round) begin
                        state_d = FIN;
                        valid_d = 1'b0;
                    end else begin
                        c_d      = c_adv;
                        d_d      = d_adv;
                        round_d  = round_adv;
                        subkey_d = pc2({c_adv, d_adv});
                    end
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            c_q      <= '0;
            d_q      <= '0;
            round_q  <= '0;
            dec_q    <= 1'b0;
            subkey_q <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            c_q      <= c_d;
            d_q      <= d_d;
            round_q  <= round_d;
            dec_q    <= dec_d;
            subkey_q <= subkey_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
        end
    end

    assign busy         = (state_q != IDLE);
    assign done         = (state_q == FIN) && !abort;
    assign subkey_valid = valid_q;
    assign subkey       = subkey_q;
    assign round_idx    = round_q;
    assign err          = err_q;
endmodule

// File: tb/tb_des_key_sched_seq.sv
// tb/tb_des_key_sched_seq.sv - scoreboard bench for des_key_sched_seq
module tb_des_key_sched_seq;
    localparam int NUM_KEYS = 3;
    localparam int KSEL_W   = 2;
    localparam logic [63:0] KEY0 = 64'h0123456789ABCDEF;
    localparam logic [63:0] KEY1 = 64'h133457799BBCDFF1;
    localparam logic [63:0] KEY2 = 64'hFEDCBA9876543210;
    localparam logic [63:0] KEYP = 64'h133457799BBCDFF0;
    localparam logic [47:0] K1C  = 48'h1B02EFFC7072;
    localparam logic [47:0] K16C = 48'hCB3D8B0E17F5;

    localparam int TB_PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };
    localparam int TB_PC2 [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic [64*NUM_KEYS-1:0] key_in;
    logic [KSEL_W-1:0]      key_sel;
    logic                   decrypt, start, abort, subkey_ready;
    logic                   busy, subkey_valid, done, err;
    logic [47:0]            subkey;
    logic [3:0]             round_idx;

    always #5 clk = ~clk;

    des_key_sched_seq #(.NUM_KEYS(NUM_KEYS), .KSEL_W(KSEL_W)) dut (
        .clk(clk), .rst_n(rst_n), .key_in(key_in), .key_sel(key_sel), .decrypt(decrypt),
        .start(start), .abort(abort), .busy(busy), .subkey_valid(subkey_valid),
        .subkey_ready(subkey_ready), .subkey(subkey), .round_idx(round_idx),
        .done(done), .err(err)
    );

    typedef struct packed {
        logic [3:0]  r;
        logic [47:0] k;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          checks = 0, errors = 0;
    int          hs_cnt = 0, done_cnt = 0, err_cnt = 0, busy_cnt = 0;
    logic [47:0] cap [16];
    logic [47:0] enc_cap [16];
    logic        stall_q = 1'b0;
    logic [47:0] stall_k;
    logic [3:0]  stall_r;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Independent model: total left shift from C0/D0 rather than stepwise rotation.
    function automatic logic [47:0] model(input logic [63:0] key, input int r);
        logic [27:0] c, d;
        logic [55:0] cd;
        logic [47:0] res;
        int          tot;
        tot = 0;
        for (int i = 0; i < 28; i++) c[27-i] = key[64-TB_PC1[i]];
        for (int i = 0; i < 28; i++) d[27-i] = key[64-TB_PC1[28+i]];
        for (int i = 0; i <= r; i++) tot += (i == 0 || i == 1 || i == 8 || i == 15) ? 1 : 2;
        for (int s = 0; s < tot; s++) begin
            c = {c[26:0], c[27]};
            d = {d[26:0], d[27]};
        end
        cd = {c, d};
        for (int i = 0; i < 48; i++) res[47-i] = cd[56-TB_PC2[i]];
        return res;
    endfunction

    task automatic push_run(input logic [63:0] key, input logic dec);
        for (int i = 0; i < 16; i++) begin
            int r;
            r = dec ? 15 - i : i;
            exp_q.push_back({4'(r), model(key, r)});
        end
    endtask

    always @(negedge clk) begin
        if (stall_q) begin
            check("hold_valid", 64'(subkey_valid), 64'd1);
            check("hold_subkey", 64'(subkey), 64'(stall_k));
            check("hold_round", 64'(round_idx), 64'(stall_r));
        end
        stall_q = subkey_valid && !subkey_ready && !abort && rst_n;
        stall_k = subkey;
        stall_r = round_idx;
        if (subkey_valid && subkey_ready && !abort && rst_n) begin
            if (exp_q.size() == 0) begin
                check("unexpected_subkey", 64'(subkey), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                mon_e = exp_q.pop_front();
                check("subkey", 64'(subkey), 64'(mon_e.k));
                check("round_idx", 64'(round_idx), 64'(mon_e.r));
            end
            if (hs_cnt < 16) cap[hs_cnt] = subkey;
            hs_cnt++;
        end
        if (done) done_cnt++;
        if (err) err_cnt++;
        if (busy) busy_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic go(input logic [KSEL_W-1:0] sel, input logic dec);
        key_sel = sel;
        decrypt = dec;
        start   = 1'b1;
        hs_cnt  = 0;
        tick();
        start   = 1'b0;
    endtask

    task automatic wait_done(input string name, input int base, input int limit);
        int n;
        n = 0;
        while (done_cnt == base && n < limit) begin
            tick();
            n++;
        end
        check({name, "_done_seen"}, 64'(done_cnt != base), 64'd1);
    endtask

    task automatic idle_outputs(input string name);
        check({name, "_busy"}, 64'(busy), 64'd0);
        check({name, "_valid"}, 64'(subkey_valid), 64'd0);
        check({name, "_subkey"}, 64'(subkey), 64'd0);
        check({name, "_round"}, 64'(round_idx), 64'd0);
        check({name, "_done"}, 64'(done), 64'd0);
        check({name, "_err"}, 64'(err), 64'd0);
    endtask

    initial begin
        int d0, e0, n;
        key_in       = {KEY2, KEY1, KEY0};
        key_sel      = '0;
        decrypt      = 1'b0;
        start        = 1'b0;
        abort        = 1'b0;
        subkey_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        idle_outputs("reset");
        rst_n = 1'b1;
        tick();

        // encrypt, ready held high
        busy_cnt = 0;
        d0 = done_cnt;
        push_run(KEY1, 1'b0);
        go(1, 1'b0);
        @(negedge clk);
        check("lat_valid_low", 64'(subkey_valid), 64'd0);
        check("lat_busy", 64'(busy), 64'd1);
        @(negedge clk);
        check("lat_valid_high", 64'(subkey_valid), 64'd1);
        check("lat_round0", 64'(round_idx), 64'd0);
        #4;
        wait_done("enc", d0, 40);
        repeat (3) tick();
        check("enc_busy_cycles", 64'(busy_cnt), 64'd18);
        check("enc_done_once", 64'(done_cnt - d0), 64'd1);
        check("enc_q_empty", 64'(exp_q.size()), 64'd0);
        check("enc_first_k1", 64'(cap[0]), 64'(K1C));
        check("enc_last_k16", 64'(cap[15]), 64'(K16C));
        for (int i = 0; i < 16; i++) enc_cap[i] = cap[i];

        // decrypt, same key
        d0 = done_cnt;
        push_run(KEY1, 1'b1);
        go(1, 1'b1);
        wait_done("dec", d0, 40);
        tick();
        check("dec_first_k16", 64'(cap[0]), 64'(K16C));
        check("dec_last_k1", 64'(cap[15]), 64'(K1C));
        for (int i = 0; i < 16; i++) check("dec_reverse", 64'(cap[i]), 64'(enc_cap[15-i]));

        // random backpressure
        d0 = done_cnt;
        push_run(KEY0, 1'b0);
        go(0, 1'b0);
        n = 0;
        while (done_cnt == d0 && n < 400) begin
            subkey_ready = ($urandom_range(0, 99) < 40);
            tick();
            n++;
        end
        check("rnd_done_seen", 64'(done_cnt != d0), 64'd1);
        check("rnd_handshakes", 64'(hs_cnt), 64'd16);
        check("rnd_q_empty", 64'(exp_q.size()), 64'd0);
        subkey_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("rnd_no_valid_after_done", 64'(subkey_valid), 64'd0);
        end
        tick();

        // bad key_sel, then a start while busy
        e0 = err_cnt;
        go(3, 1'b0);
        @(negedge clk);
        check("badsel_err", 64'(err), 64'd1);
        check("badsel_busy", 64'(busy), 64'd0);
        @(negedge clk);
        check("badsel_err_pulse", 64'(err), 64'd0);
        check("badsel_no_valid", 64'(subkey_valid), 64'd0);
        tick();
        check("badsel_err_count", 64'(err_cnt - e0), 64'd1);
        d0 = done_cnt;
        push_run(KEY2, 1'b0);
        go(2, 1'b0);
        repeat (4) tick();
        e0 = err_cnt;
        key_sel = 0;
        decrypt = 1'b1;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        wait_done("busy_start", d0, 40);
        check("busy_start_no_err", 64'(err_cnt - e0), 64'd0);
        check("busy_start_q_empty", 64'(exp_q.size()), 64'd0);

        // abort after the 5th handshake, then immediate restart
        tick();
        push_run(KEY1, 1'b0);
        go(1, 1'b0);
        n = 0;
        while (hs_cnt < 5 && n < 40) begin
            tick();
            n++;
        end
        d0 = done_cnt;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        @(negedge clk);
        check("abort_valid", 64'(subkey_valid), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_handshakes", 64'(hs_cnt), 64'd5);
        check("abort_q_left", 64'(exp_q.size()), 64'd11);
        exp_q.delete();
        tick();
        check("abort_no_done", 64'(done_cnt - d0), 64'd0);
        push_run(KEY1, 1'b0);
        go(1, 1'b0);
        wait_done("restart", d0, 40);
        check("restart_k1", 64'(cap[0]), 64'(K1C));
        tick();

        // asynchronous reset mid-run
        push_run(KEY0, 1'b1);
        go(0, 1'b1);
        repeat (6) tick();
        d0 = done_cnt;
        rst_n = 1'b0;
        #1;
        idle_outputs("midrst");
        tick();
        rst_n = 1'b1;
        exp_q.delete();
        repeat (4) tick();
        check("midrst_no_done", 64'(done_cnt - d0), 64'd0);
        check("midrst_idle_busy", 64'(busy), 64'd0);

        // key with a bad parity byte
        key_in[127:64] = KEYP;
        e0 = err_cnt;
`ifdef PARITY_CHECK_EN
        go(1, 1'b0);
        @(negedge clk);
        check("parity_err", 64'(err), 64'd1);
        check("parity_busy", 64'(busy), 64'd0);
        repeat (3) tick();
        check("parity_no_run", 64'(hs_cnt), 64'd0);
`else
        d0 = done_cnt;
        push_run(KEYP, 1'b0);
        go(1, 1'b0);
        wait_done("noparity", d0, 40);
        check("noparity_no_err", 64'(err_cnt - e0), 64'd0);
        check("noparity_q_empty", 64'(exp_q.size()), 64'd0);
`endif
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
